// File: rtl/perceptron_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_layer_seq
// Purpose  : One layer of N_NEURONS perceptrons with N_INPUTS inputs each.
//            A single signed MAC is time-multiplexed over all neurons.
//            Weights, biases and thresholds are loaded serially over a config
//            stream. Input vectors arrive over a valid/ready stream, and the
//            previous result vector can be fed back as the next input
//            (recurrent mode).
// Optional : PERCEPTRON_LAYER_SAT_EN - saturate outputs to the DATA_W signed
//            range instead of truncating.
// Ports    : clk, reset        - clock, asynchronous active-high reset
//            cfg_valid/data/ready - config stream. Per neuron the word order
//                               is w[0..N_INPUTS-1], bias, threshold.
//            in_valid/data/ready  - input vector stream, x[0] first
//            recur_start       - compute again with out_vector as the inputs
//            busy              - high whenever the FSM is not idle
//            out_valid         - one-cycle pulse when out_vector is updated
//            out_vector        - neuron j in bits [j*DATA_W +: DATA_W]
//            out_sel/out_word  - combinational read port; 0 when out of range
// Revision : 1.0 - initial release
// ============================================================================
module perceptron_layer_seq #(
  parameter int DATA_W     = 8,
  parameter int N_INPUTS   = 4,
  parameter int N_NEURONS  = 4,
  parameter int FRAC_SHIFT = 0
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 cfg_valid,
  input  logic [DATA_W-1:0]                                    cfg_data,
  output logic                                                 cfg_ready,
  input  logic                                                 in_valid,
  input  logic [DATA_W-1:0]                                    in_data,
  output logic                                                 in_ready,
  input  logic                                                 recur_start,
  output logic                                                 busy,
  output logic                                                 out_valid,
  output logic [N_NEURONS*DATA_W-1:0]                          out_vector,
  input  logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] out_sel,
  output logic [DATA_W-1:0]                                    out_word
);

  localparam int SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int IN_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int NJ_W  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int CK_W  = $clog2(N_INPUTS + 2);
  localparam int ACC_W = 2*DATA_W + $clog2(N_INPUTS) + 1;
  localparam int PRD_W = 2*DATA_W;
  localparam bit RECUR_OK = (N_INPUTS == N_NEURONS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CFG  = 3'd1,
    S_IN   = 3'd2,
    S_MAC  = 3'd3,
    S_ACT  = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Config position is tracked as (neuron, word-within-neuron) so no
  // division by N_INPUTS+2 is needed to decode the flat word index.
  logic [NJ_W-1:0] cfg_j;
  logic [CK_W-1:0] cfg_k;
  logic [IN_W-1:0] in_cnt;
  logic [IN_W-1:0] mac_k;
  logic [NJ_W-1:0] mac_j;

  logic signed [DATA_W-1:0] w     [N_NEURONS][N_INPUTS];
  logic signed [DATA_W-1:0] bias  [N_NEURONS];
  logic signed [DATA_W-1:0] th    [N_NEURONS];
  logic signed [DATA_W-1:0] x     [N_INPUTS];
  logic signed [DATA_W-1:0] y_buf [N_NEURONS];
  logic signed [ACC_W-1:0]  acc;

  logic cfg_last_k, cfg_last_j, in_last, mac_last_k, mac_last_j;
  logic recur_req, cfg_fire, in_fire, recur_go;

  assign cfg_last_k = (cfg_k == CK_W'(N_INPUTS + 1));
  assign cfg_last_j = (cfg_j == NJ_W'(N_NEURONS - 1));
  assign in_last    = (in_cnt == IN_W'(N_INPUTS - 1));
  assign mac_last_k = (mac_k == IN_W'(N_INPUTS - 1));
  assign mac_last_j = (mac_j == NJ_W'(N_NEURONS - 1));

  assign recur_req = recur_start && RECUR_OK;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;
  assign recur_go  = (state == S_IDLE) && !cfg_valid && recur_req;

  // Feedback path only exists when the output vector can serve as an input
  // vector; otherwise recur_start is never acted upon.
  logic [N_INPUTS*DATA_W-1:0] recur_vec;
  generate
    if (RECUR_OK) begin : g_recur
      assign recur_vec = out_vector;
    end else begin : g_no_recur
      assign recur_vec = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cfg_ready = 1'b1;
        // An input word is only taken when neither config nor a recurrent
        // start claims the cycle.
        in_ready  = !cfg_valid && !recur_req && !reset;
        if (cfg_valid)      state_nxt = S_CFG;
        else if (recur_req) state_nxt = S_MAC;
        else if (in_valid)  state_nxt = in_last ? S_MAC : S_IN;
      end
      S_CFG: begin
        cfg_ready = 1'b1;
        if (cfg_valid && cfg_last_k && cfg_last_j) state_nxt = S_IDLE;
      end
      S_IN: begin
        in_ready = !reset;
        if (in_valid && in_last) state_nxt = S_MAC;
      end
      S_MAC: begin
        if (mac_last_k) state_nxt = S_ACT;
      end
      S_ACT: begin
        state_nxt = mac_last_j ? S_IDLE : S_MAC;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // MAC and activation datapath
  // --------------------------------------------------------------------------
  logic signed [PRD_W-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext, th_ext, acc_base, shifted;
  logic signed [DATA_W-1:0] y_val, y_fit;

  assign prod     = x[mac_k] * w[mac_j][mac_k];
  assign prod_ext = {{(ACC_W-PRD_W){prod[PRD_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){bias[mac_j][DATA_W-1]}}, bias[mac_j]};
  assign th_ext   = {{(ACC_W-DATA_W){th[mac_j][DATA_W-1]}}, th[mac_j]};
  // First product of each neuron starts from the bias instead of the old sum.
  assign acc_base = (mac_k == '0) ? bias_ext : acc;
  assign shifted  = acc >>> FRAC_SHIFT;

`ifdef PERCEPTRON_LAYER_SAT_EN
  // Value fits when every bit from the output sign bit upward is identical.
  logic [ACC_W-DATA_W:0] hi_bits;
  assign hi_bits = shifted[ACC_W-1:DATA_W-1];
  always_comb begin
    y_fit = DATA_W'(shifted);
    if (!((hi_bits == '0) || (hi_bits == '1))) begin
      y_fit = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                               : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign y_fit = DATA_W'(shifted);
`endif

  // Gating compares the unshifted sum; equality passes.
  assign y_val = (acc >= th_ext) ? y_fit : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_j      <= '0;
      cfg_k      <= '0;
      in_cnt     <= '0;
      mac_k      <= '0;
      mac_j      <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_vector <= '0;
      for (int j = 0; j < N_NEURONS; j++) begin
        bias[j]  <= '0;
        th[j]    <= '0;
        y_buf[j] <= '0;
        for (int k = 0; k < N_INPUTS; k++) w[j][k] <= '0;
      end
      for (int k = 0; k < N_INPUTS; k++) x[k] <= '0;
    end else begin
      out_valid <= 1'b0;

      if (cfg_fire) begin
        if (cfg_k < CK_W'(N_INPUTS))      w[cfg_j][cfg_k[IN_W-1:0]] <= cfg_data;
        else if (cfg_k == CK_W'(N_INPUTS)) bias[cfg_j]              <= cfg_data;
        else                               th[cfg_j]                <= cfg_data;
        if (cfg_last_k) begin
          cfg_k <= '0;
          cfg_j <= cfg_last_j ? '0 : cfg_j + 1'b1;
        end else begin
          cfg_k <= cfg_k + 1'b1;
        end
      end

      if (in_fire) begin
        x[in_cnt] <= in_data;
        in_cnt    <= in_last ? '0 : in_cnt + 1'b1;
      end

      if (recur_go) begin
        for (int k = 0; k < N_INPUTS; k++) x[k] <= recur_vec[k*DATA_W +: DATA_W];
      end

      if (state == S_MAC) begin
        acc   <= acc_base + prod_ext;
        mac_k <= mac_last_k ? '0 : mac_k + 1'b1;
      end

      if (state == S_ACT) begin
        y_buf[mac_j] <= y_val;
        if (mac_last_j) begin
          mac_j     <= '0;
          out_valid <= 1'b1;
          // Publish the whole vector at once; the last neuron's result is
          // still on y_val this cycle.
          for (int j = 0; j < N_NEURONS; j++) begin
            out_vector[j*DATA_W +: DATA_W] <= (j == N_NEURONS - 1) ? y_val : y_buf[j];
          end
        end else begin
          mac_j <= mac_j + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read port
  // --------------------------------------------------------------------------
  always_comb begin
    out_word = '0;
    for (int j = 0; j < N_NEURONS; j++) begin
      if (out_sel == SEL_W'(j)) out_word = out_vector[j*DATA_W +: DATA_W];
    end
  end

endmodule
`default_nettype wire

// File: doc/perceptron_layer_seq.md
Name: perceptron_layer_seq

Overview:
Parametrised successor of the fixed 4x4 perceptron network. It implements one layer of N_NEURONS perceptrons, each with N_INPUTS inputs, using a single time-multiplexed signed MAC. Weights, biases and thresholds are loaded serially over a config stream. Input vectors arrive through a valid/ready stream, and results can be fed back as the next input vector (recurrent mode). It sits between the byte-wide host data path and the output selector mux.

Parameters:
DATA_W, 8, width of inputs, weights, bias, threshold and outputs (signed two's complement)
N_INPUTS, 4, inputs per neuron (>=1)
N_NEURONS, 4, neurons in the layer (>=1)
FRAC_SHIFT, 0, arithmetic right shift applied to the sum before output truncation

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cfg_valid  in  1  config word valid
cfg_data  in  DATA_W  config word
cfg_ready  out  1  config word accepted when cfg_valid&cfg_ready
in_valid  in  1  input word valid
in_data  in  DATA_W  input word
in_ready  out  1  input word accepted when in_valid&in_ready
recur_start  in  1  use current outputs as the input vector and compute
busy  out  1  high in any state except IDLE
out_valid  out  1  one-cycle pulse when out_vector is updated
out_vector  out  N_NEURONS*DATA_W  neuron j in bits [j*DATA_W +: DATA_W]
out_sel  in  $clog2(N_NEURONS) (min 1)  read select
out_word  out  DATA_W  combinational out_vector slice selected by out_sel; 0 if out_sel>=N_NEURONS

Behaviour:
- Reset (async, high): state=IDLE; all counters 0; all weights, biases, thresholds, input buffer and out_vector = 0; out_valid=0; busy=0; cfg_ready=1; in_ready=0.
- Config order, per neuron j=0..N_NEURONS-1: w[j][0..N_INPUTS-1], bias[j], th[j]. Total CFG_WORDS = N_NEURONS*(N_INPUTS+2).
- States: IDLE, CFG, IN, MAC, ACT.
- IDLE:
  - cfg_valid: accept the word and go to CFG. cfg_valid has priority over in_valid and recur_start in the same cycle.
  - Otherwise, if recur_start and N_INPUTS==N_NEURONS: copy out_vector to the input buffer and go to MAC. recur_start is ignored if the sizes differ.
  - Otherwise, if in_valid: accept in_data as x[0] and go to IN. When N_INPUTS==1, go straight to MAC.
- cfg_ready=1 only in IDLE and CFG. in_ready=1 only in IDLE (with cfg_valid=0) and IN.
- CFG: one word per handshake; cfg_cnt 0..CFG_WORDS-1. After the last word, return to IDLE and clear cfg_cnt. Inputs and recur_start are ignored in CFG. A partial config persists until completed; there is no timeout.
- IN: in_cnt counts accepted words. After word N_INPUTS-1, go to MAC.
- MAC: one product per cycle, acc += x[k]*w[j][k], for k=0..N_INPUTS-1. acc is preloaded with sign-extended bias[j] when k=0.
- ACT (1 cycle):
  - s = acc >>> FRAC_SHIFT.
  - If acc >= sign-extended th[j] (equality passes): y[j] = s[DATA_W-1:0]. Otherwise y[j] = 0.
  - Then go to the next neuron in MAC, or, after neuron N_NEURONS-1, write out_vector, pulse out_valid and return to IDLE.
- ACC_W = 2*DATA_W + $clog2(N_INPUTS) + 1, signed. The accumulator never overflows.
- Latency: N_NEURONS*(N_INPUTS+1) cycles from the last input handshake (or recur_start) to the out_valid pulse. out_vector updates atomically; the old values hold during compute.
- Config words arriving while busy are not accepted (cfg_ready=0). Weights are never modified mid-compute.
- Reset mid-operation aborts everything and clears all parameters.

Optional Feature:
- Macro PERCEPTRON_LAYER_SAT_EN.
- Defined: y[j] is s saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1] instead of truncated.
- Undefined: plain truncation to DATA_W bits.
- Threshold gating is identical in both cases.

Test Plan:
Common setup for all scenarios: DATA_W=8, N_INPUTS=2, N_NEURONS=2, FRAC_SHIFT=0.
1. Config 1,2,3,0,-1,-1,0,0, then inputs 4,5 -> exactly 6 cycles after the second input handshake, out_valid pulses with y0=17, y1=0; out_sel=0 gives out_word=17.
2. Following scenario 1, pulse recur_start -> after 6 cycles y0=20 (17+0+3), y1=0.
3. Config neuron0 w=100,100 b=0 th=0; inputs 100,100 -> sum 20000: y0=0x20 without the macro, 127 with PERCEPTRON_LAYER_SAT_EN.
4. Threshold boundary: neuron0 w=1,1 b=0 th=9, inputs 4,5 -> y0=9 (equality passes); th=10 -> y0=0.
5. Assert cfg_valid and in_valid together in IDLE -> the config word is taken and in_ready=0. Drive cfg_valid during MAC -> cfg_ready=0 and the parameters are unchanged.
6. Assert reset during MAC -> busy=0, out_vector=0 and out_valid stays 0. A subsequent compute with no config produces all zeros.
